// File: rtl/nor_read_ctrl.sv
// nor_read_ctrl: bus-side fast-read initiator for SPI (1-1-1) / QSPI (4-4-4) NOR flash.
// Keeps CSB low after a read so an address-sequential follow-up streams straight from DATA.
module nor_read_ctrl #(
  parameter string      NOR_TYPE   = "spi",
  parameter logic [7:0] CMD_SPI    = 8'h0B,
  parameter logic [7:0] CMD_QSPI   = 8'hEB,
  parameter int         DUMMY_SPI  = 15,
  parameter int         DUMMY_QSPI = 10,
  parameter int         CSB_HIGH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [23:0] addr,
  input  logic [1:0]  size,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        nor_sck,
  output logic        nor_csb,
  output logic [3:0]  nor_sio_o,
  output logic [3:0]  nor_sio_oe,
  input  logic [3:0]  nor_sio_i
);
  localparam bit         QUAD       = (NOR_TYPE == "qspi");
  localparam logic [7:0] CMD_BYTE   = QUAD ? CMD_QSPI : CMD_SPI;
  localparam logic [7:0] CMD_LAST   = QUAD ? 8'd1 : 8'd7;
  localparam logic [7:0] ADDR_LAST  = QUAD ? 8'd5 : 8'd23;
  localparam logic [7:0] DUMMY_LAST = 8'(QUAD ? DUMMY_QSPI - 1 : DUMMY_SPI - 1);

  typedef enum logic [2:0] {IDLE, GAP, CMD, ADDR, DUMMY, DATA, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  nb_q, nb_d;
  logic [23:0] a_q, a_d, nxt_q, nxt_d;
  logic [31:0] sr_q, sr_d, dsr_q, dsr_d, rdata_q, rdata_d;
  logic        sck_q, sck_d, csb_q, csb_d, ack_q, ack_d;
  logic [3:0]  sio_o_q, sio_o_d, oe_q, oe_d;
  logic [2:0]  req_nb;
  logic [7:0]  data_last;
  logic        last, start;

  assign req_nb    = size == 2'd0 ? 3'd1 : size == 2'd1 ? 3'd2 : 3'd4;
  assign data_last = (QUAD ? {4'b0, nb_q, 1'b0} : {2'b0, nb_q, 3'b0}) - 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nb_d    = nb_q;
    a_d     = a_q;
    nxt_d   = nxt_q;
    sr_d    = sr_q;
    dsr_d   = dsr_q;
    rdata_d = rdata_q;
    sck_d   = 1'b0;
    csb_d   = csb_q;
    sio_o_d = sio_o_q;
    oe_d    = oe_q;
    ack_d   = 1'b0;
    start   = 1'b0;
    last    = state_q == CMD   ? cnt_q == CMD_LAST :
              state_q == ADDR  ? cnt_q == ADDR_LAST :
              state_q == DUMMY ? cnt_q == DUMMY_LAST : cnt_q == data_last;
    case (state_q)
      IDLE: start = req;
      // the final GAP cycle doubles as IDLE so CSB stays high exactly CSB_HIGH cycles
      GAP: begin
        state_d = cnt_q <= 8'd1 ? IDLE : GAP;
        cnt_d   = cnt_q - 8'd1;
        start   = cnt_q <= 8'd1 && req;
      end
      // ack_q masks the request still held during the ack cycle
      HOLD: if (req && !ack_q) begin
        state_d = addr == nxt_q ? DATA : GAP;
        csb_d   = addr != nxt_q;
        cnt_d   = addr == nxt_q ? 8'd0 : 8'(CSB_HIGH);
        a_d     = addr;
        nb_d    = req_nb;
      end
      default: if (!sck_q) sck_d = 1'b1;
      else begin
        cnt_d   = last ? 8'd0 : cnt_q + 8'd1;
        sio_o_d = QUAD ? sr_q[31:28] : {3'b0, sr_q[31]};
        sr_d    = QUAD ? {sr_q[27:0], 4'b0} : {sr_q[30:0], 1'b0};
        dsr_d   = QUAD ? {dsr_q[27:0], nor_sio_i} : {dsr_q[30:0], nor_sio_i[1]};
        if (last) begin
          state_d = state_q == CMD ? ADDR : state_q == ADDR ? DUMMY : state_q == DUMMY ? DATA : HOLD;
          oe_d    = state_q == ADDR ? 4'h0 : oe_q;
        end
        // bytes arrive in address order, so the first byte sits highest in dsr
        if (last && state_q == DATA) begin
          ack_d   = 1'b1;
          rdata_d = nb_q == 3'd1 ? {24'b0, dsr_d[7:0]} :
                    nb_q == 3'd2 ? {16'b0, dsr_d[7:0], dsr_d[15:8]} :
                                   {dsr_d[7:0], dsr_d[15:8], dsr_d[23:16], dsr_d[31:24]};
          nxt_d   = a_q + {21'b0, nb_q};
        end
      end
    endcase
    if (start) begin
      state_d = CMD;
      csb_d   = 1'b0;
      cnt_d   = 8'd0;
      a_d     = addr;
      nb_d    = req_nb;
      sio_o_d = QUAD ? CMD_BYTE[7:4] : {3'b0, CMD_BYTE[7]};
      sr_d    = QUAD ? {CMD_BYTE[3:0], addr, 4'b0} : {CMD_BYTE[6:0], addr, 1'b0};
      oe_d    = QUAD ? 4'hF : 4'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= GAP;
      cnt_q   <= 8'(CSB_HIGH);
      nb_q    <= '0;
      a_q     <= '0;
      nxt_q   <= '0;
      sr_q    <= '0;
      dsr_q   <= '0;
      rdata_q <= '0;
      sck_q   <= 1'b0;
      csb_q   <= 1'b1;
      ack_q   <= 1'b0;
      sio_o_q <= '0;
      oe_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nb_q    <= nb_d;
      a_q     <= a_d;
      nxt_q   <= nxt_d;
      sr_q    <= sr_d;
      dsr_q   <= dsr_d;
      rdata_q <= rdata_d;
      sck_q   <= sck_d;
      csb_q   <= csb_d;
      ack_q   <= ack_d;
      sio_o_q <= sio_o_d;
      oe_q    <= oe_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign nor_sck    = sck_q;
  assign nor_csb    = csb_q;
  assign nor_sio_o  = sio_o_q;
  assign nor_sio_oe = oe_q;
endmodule

// File: tb/tb_nor_read_ctrl.sv
// tb_nor_read_ctrl: drives an spi and a qspi controller against a 512-byte flash model (array[n] = n & 0xFF).
module tb_nor_read_ctrl;
  localparam int CSB_HIGH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req[2];
  logic [23:0] addr[2];
  logic [1:0]  size[2];
  logic        ack[2];
  logic [31:0] rdata[2];
  logic        sck[2], csb[2];
  logic [3:0]  sio_o[2], oe[2], fi[2];

  int checks = 0;
  int errors = 0;

  bit          hold[2];
  logic [23:0] nxt[2];

  logic [7:0]  mem[512];
  int          cnt[2];
  logic [7:0]  fcmd[2];
  logic [23:0] fa[2];

  always #5 clk = ~clk;

  nor_read_ctrl #(.NOR_TYPE("spi"), .CSB_HIGH(CSB_HIGH)) dut_spi (
    .clk(clk), .rstn(rstn), .req(req[0]), .addr(addr[0]), .size(size[0]),
    .ack(ack[0]), .rdata(rdata[0]), .nor_sck(sck[0]), .nor_csb(csb[0]),
    .nor_sio_o(sio_o[0]), .nor_sio_oe(oe[0]), .nor_sio_i(fi[0])
  );

  nor_read_ctrl #(.NOR_TYPE("qspi"), .CSB_HIGH(CSB_HIGH)) dut_qspi (
    .clk(clk), .rstn(rstn), .req(req[1]), .addr(addr[1]), .size(size[1]),
    .ack(ack[1]), .rdata(rdata[1]), .nor_sck(sck[1]), .nor_csb(csb[1]),
    .nor_sio_o(sio_o[1]), .nor_sio_oe(oe[1]), .nor_sio_i(fi[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  initial for (int i = 0; i < 512; i++) mem[i] = 8'(i);

  // Flash model: acts at the end of each SCK high phase (mode 0), capturing
  // command/address and presenting the next data unit for the following SCK.
  always @(posedge clk) begin
    int cc, ac, dm, bpb, d;
    logic [7:0] b;
    for (int g = 0; g < 2; g++) begin
      cc  = g ? 2 : 8;
      ac  = g ? 6 : 24;
      dm  = g ? 10 : 15;
      bpb = g ? 2 : 8;
      if (sck[g] === 1'b1) chk($sformatf("sck_while_csb%0d", g), csb[g], 0);
      if (csb[g] === 1'b1) begin
        cnt[g] = 0;
        fi[g] <= 4'h0;
      end else if (sck[g] === 1'b1) begin
        chk($sformatf("oe%0d_c%0d", g, cnt[g]), oe[g], cnt[g] < cc + ac ? (g ? 4'hF : 4'h1) : 4'h0);
        if (cnt[g] < cc) fcmd[g] = g ? {fcmd[g][3:0], sio_o[g]} : {fcmd[g][6:0], sio_o[g][0]};
        else if (cnt[g] < cc + ac) fa[g] = g ? {fa[g][19:0], sio_o[g]} : {fa[g][22:0], sio_o[g][0]};
        cnt[g]++;
        if (cnt[g] >= cc + ac + dm) begin
          d = cnt[g] - (cc + ac + dm);
          b = mem[(int'(fa[g]) + d / bpb) % 512];
          fi[g] <= g ? ((d % 2 == 0) ? b[7:4] : b[3:0]) : {2'b0, b[7 - d % 8], 1'b0};
        end
      end
    end
  end

  task automatic read(input int g, input logic [23:0] a, input logic [1:0] sz);
    int nb, n_exp, lat, nsck, nhi;
    bit cont, nonseq, got;
    logic [31:0] exp;
    nb     = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    cont   = hold[g] && a == nxt[g];
    nonseq = hold[g] && !cont;
    n_exp  = cont ? (g ? 2 : 8) * nb : (g ? 8 + 10 + 2 * nb : 32 + 15 + 8 * nb);
    exp    = 0;
    for (int i = 0; i < nb; i++) exp |= 32'(8'(a + 24'(i))) << (8 * i);
    req[g] = 1'b1;
    addr[g] = a;
    size[g] = sz;
    lat = 0; nsck = 0; nhi = 0; got = 0;
    while (!got && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (ack[g]) got = 1;
      else begin
        nsck += int'(sck[g]);
        nhi  += int'(csb[g]);
      end
    end
    chk($sformatf("ack%0d@%h", g, a), got, 1);
    chk($sformatf("rdata%0d@%h", g, a), rdata[g], exp);
    chk($sformatf("latency%0d@%h", g, a), lat, (nonseq ? CSB_HIGH : 0) + 2 * n_exp + 1);
    chk($sformatf("sck_cycles%0d@%h", g, a), nsck, n_exp);
    chk($sformatf("csb_high%0d@%h", g, a), nhi, nonseq ? CSB_HIGH : 0);
    if (!cont) begin
      chk($sformatf("cmd%0d@%h", g, a), fcmd[g], g ? 8'hEB : 8'h0B);
      chk($sformatf("addr%0d@%h", g, a), fa[g], a);
    end
    hold[g] = 1;
    nxt[g] = a + 24'(nb);
    req[g] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("ack_pulse%0d@%h", g, a), ack[g], 0);
  endtask

  initial begin
    int g, any_ack;
    logic [23:0] a;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0;
      addr[i] = '0;
      size[i] = '0;
      hold[i] = 0;
      nxt[i] = '0;
    end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_csb%0d", i), csb[i], 1);
      chk($sformatf("rst_sck%0d", i), sck[i], 0);
      chk($sformatf("rst_oe%0d", i), oe[i], 0);
      chk($sformatf("rst_sio_o%0d", i), sio_o[i], 0);
      chk($sformatf("rst_ack%0d", i), ack[i], 0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 0);
    end
    rstn = 1'b1;
    repeat (CSB_HIGH + 2) @(posedge clk);
    #1;
    read(0, 24'h000010, 2'd0);
    read(0, 24'h000020, 2'd2);
    read(0, 24'h000024, 2'd2);
    read(0, 24'h000030, 2'd2);
    read(0, 24'h000100, 2'd0);
    read(1, 24'h000040, 2'd1);
    read(0, 24'hFFFFFC, 2'd2);
    read(0, 24'h000000, 2'd2);
    // abort a non-sequential spi read while it is shifting the address
    req[0] = 1'b1;
    addr[0] = 24'h000777;
    size[0] = 2'd0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_in_addr_oe", oe[0], 4'h1);
    chk("abort_in_addr_csb", csb[0], 0);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("abort_csb", csb[0], 1);
    chk("abort_sck", sck[0], 0);
    chk("abort_oe", oe[0], 0);
    chk("abort_ack", ack[0], 0);
    req[0] = 1'b0;
    any_ack = 0;
    repeat (2) begin
      @(posedge clk); #1;
      any_ack += int'(ack[0]) + int'(ack[1]);
    end
    rstn = 1'b1;
    hold[0] = 0;
    hold[1] = 0;
    repeat (CSB_HIGH + 2) begin
      @(posedge clk); #1;
      any_ack += int'(ack[0]) + int'(ack[1]);
    end
    chk("abort_no_ack", any_ack, 0);
    read(0, 24'h000005, 2'd0);
    read(1, 24'h0001FE, 2'd2);
    repeat (12) begin
      g = int'($urandom_range(0, 1));
      a = $urandom_range(0, 2) == 0 ? nxt[g] : 24'($urandom);
      read(g, a, 2'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
